// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller:
// FSM state encoding, default operand width and comparator-bundle layout.
package sar_search_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Comparator result bundle {G, E, L}
  localparam int unsigned CMP_W     = 3;
  localparam int unsigned CMP_G_BIT = 2;
  localparam int unsigned CMP_E_BIT = 1;
  localparam int unsigned CMP_L_BIT = 0;

  // A legal comparator code has exactly one of G/E/L asserted
  function automatic logic cmp_legal(input logic [CMP_W-1:0] c);
    return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
  endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search controller. Presents a trial value to an
// external combinational magnitude comparator and resolves the unknown
// target MSB-first from the returned G/E/L code.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               request a new search (sampled in IDLE only)
//   cmp_g/cmp_e/cmp_l   comparator result: target >, ==, < trial
//   trial               registered trial value to the comparator
//   busy                search in progress
//   done                one-cycle completion pulse
//   result/found/err    resolved value, equality confirmed, illegal code seen
module sar_search
  import sar_search_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_g,
  input  logic             cmp_e,
  input  logic             cmp_l,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   trial_q, trial_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               found_q, found_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CMP_W-1:0]   cmp;
  logic               legal;

  assign cmp   = {cmp_g, cmp_e, cmp_l};
  assign legal = cmp_legal(cmp);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= IDX_W'(WIDTH - 1);
      trial_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    trial_d  = trial_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d          = ST_STEP;
          trial_d          = '0;
          trial_d[WIDTH-1] = 1'b1;
          idx_d            = IDX_W'(WIDTH - 1);
          busy_d           = 1'b1;
          result_d         = '0;
          found_d          = 1'b0;
          err_d            = 1'b0;
        end
      end

      ST_STEP: begin
        if (!legal || cmp[CMP_E_BIT]) begin
          // Illegal code or early equality both terminate on the current trial
          state_d  = ST_DONE;
          result_d = trial_q;
          found_d  = legal;
          err_d    = !legal;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          if (cmp[CMP_L_BIT]) begin
            trial_d[idx_q] = 1'b0;
          end
          if (idx_q != '0) begin
            idx_d          = idx_q - IDX_W'(1);
            trial_d[idx_d] = 1'b1;
          end else begin
            state_d = ST_VERIFY;
          end
        end
      end

      ST_VERIFY: begin
        state_d  = ST_DONE;
        result_d = trial_q;
        found_d  = legal && cmp[CMP_E_BIT];
        err_d    = !legal;
        busy_d   = 1'b0;
        done_d   = 1'b1;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign trial  = trial_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign found  = found_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: behavioural comparator holding the
// target, arithmetic reference for the expected trial sequence, directed
// cases plus randomized targets and fault injection.
module tb_sar_search;

  localparam int unsigned W = 8;
  localparam int MAX_CYC = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         cmp_g, cmp_e, cmp_l;
  logic [W-1:0] trial, result;
  logic         busy, done, found, err;

  logic [W-1:0] target;
  int           inj_step;
  int           cur_cyc;
  int           n_tests = 0;
  int           n_fail  = 0;

  sar_search #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .cmp_g (cmp_g),
    .cmp_e (cmp_e),
    .cmp_l (cmp_l),
    .trial (trial),
    .busy  (busy),
    .done  (done),
    .result(result),
    .found (found),
    .err   (err)
  );

  always #5 clk = ~clk;

  // Comparator model; an injected cycle returns the illegal code G=L=1
  always_comb begin
    cmp_g = (target > trial);
    cmp_e = (target == trial);
    cmp_l = (target < trial);
    if (inj_step >= 0 && cur_cyc == inj_step) begin
      cmp_g = 1'b1;
      cmp_e = 1'b0;
      cmp_l = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Trial presented at step i: target's top i bits already resolved, next bit set
  function automatic logic [W-1:0] exp_trial(input logic [W-1:0] tgt, input int i);
    logic [W-1:0] ones;
    logic [W-1:0] top;
    ones = '1;
    if (i >= int'(W)) return tgt;
    top = (i == 0) ? '0 : (tgt & ~(ones >> i));
    return top | (W'(1) << (int'(W) - 1 - i));
  endfunction

  // Number of compare cycles: first step whose trial equals the target, else VERIFY
  function automatic int exp_cycles(input logic [W-1:0] tgt);
    for (int i = 0; i < int'(W); i++) begin
      if (exp_trial(tgt, i) == tgt) return i + 1;
    end
    return int'(W) + 1;
  endfunction

  task automatic run_search(input logic [W-1:0] tgt, input int inj,
                            input int start_pulse, input int rst_at);
    int  n;
    bit  aborted;
    logic [W-1:0] exp_res;
    target   = tgt;
    inj_step = inj;
    cur_cyc  = -1;
    aborted  = 1'b0;
    n        = (inj >= 0) ? inj + 1 : exp_cycles(tgt);
    exp_res  = (inj >= 0) ? exp_trial(tgt, inj) : tgt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cur_cyc = 0;
    while (!done && cur_cyc < MAX_CYC && !aborted) begin
      if (cur_cyc < n) begin
        check_eq($sformatf("trial t=%0h c=%0d", tgt, cur_cyc), 32'(trial), 32'(exp_trial(tgt, cur_cyc)));
        check_eq("busy_run", 32'(busy), 32'd1);
      end
      if (cur_cyc == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_trial", 32'(trial), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        check_eq("rst_no_done", 32'(done), 32'd0);
        aborted = 1'b1;
      end else begin
        start = (cur_cyc == start_pulse);
        @(negedge clk);
        start = 1'b0;
        cur_cyc++;
      end
    end
    inj_step = -1;
    if (!aborted) begin
      check_eq($sformatf("latency t=%0h", tgt), 32'(cur_cyc), 32'(n));
      check_eq("done", 32'(done), 32'd1);
      check_eq("busy_done", 32'(busy), 32'd0);
      check_eq($sformatf("result t=%0h", tgt), 32'(result), 32'(exp_res));
      check_eq("found", 32'(found), (inj >= 0) ? 32'd0 : 32'd1);
      check_eq("err", 32'(err), (inj >= 0) ? 32'd1 : 32'd0);
      @(negedge clk);
      check_eq("done_pulse", 32'(done), 32'd0);
      check_eq("result_hold", 32'(result), 32'(exp_res));
    end
  endtask

  initial begin
    int t;
    rst_n    = 1'b0;
    start    = 1'b0;
    target   = '0;
    inj_step = -1;
    cur_cyc  = -1;
    repeat (2) @(negedge clk);
    check_eq("reset_trial", 32'(trial), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_result", 32'(result), 32'd0);
    check_eq("reset_found", 32'(found), 32'd0);
    check_eq("reset_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    run_search(8'hA5, -1, -1, -1);
    run_search(8'h80, -1, -1, -1);
    run_search(8'h00, -1, -1, -1);
    run_search(8'hFF, -1, -1, -1);
    run_search(8'h5A, 2, -1, -1);
    run_search(8'h5A, -1, -1, -1);
    run_search(8'h3C, -1, 2, -1);
    run_search(8'h3C, -1, -1, 3);
    run_search(8'h3C, -1, -1, -1);

    // start held through DONE: ignored there, accepted in the following IDLE
    target = 8'h80;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    check_eq("chain_busy0", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("chain_done", 32'(done), 32'd1);
    check_eq("chain_busy_done", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("chain_ignored", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check_eq("chain_accept", 32'(busy), 32'd1);
    check_eq("chain_trial", 32'(trial), 32'h80);
    t = 0;
    while (!done && t < MAX_CYC) begin
      @(negedge clk);
      t++;
    end
    check_eq("chain_result", 32'(result), 32'h80);
    check_eq("chain_found", 32'(found), 32'd1);
    @(negedge clk);

    for (int k = 0; k < 24; k++) begin
      logic [W-1:0] tg;
      int n;
      tg = W'($urandom);
      n  = exp_cycles(tg);
      if (k % 4 == 3) run_search(tg, int'($urandom_range(0, n - 1)), -1, -1);
      else            run_search(tg, -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
